fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_bfm_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_bfm_pkg.sv
// Shared constants and FSM encodings for the FIFO write-side arbiter.
package fifo_bfm_pkg;

  // Packet framing bytes used by the packet sources.
  localparam logic [7:0] SOP = 8'hAA;
  localparam logic [7:0] EOP = 8'h53;

  localparam int DEFAULT_DATA_W  = 128;
  localparam int DEFAULT_NUM_REQ = 3;

  // IDLE: no holding register occupied; ARB: at least one occupied.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ARB  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requesting index at or after the pointer wins.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Scan from the pointer, wrapping, and grant the first active request.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Collects packets from NUM_REQ sources into one-entry holding registers and
// writes them round-robin into a shared FIFO, one registered write per cycle.
//
// Handshake: a source packet transfers at a rising edge where
// req_valid[i] & req_ready[i]; req_ready[i] is ~hold_vld[i] straight from a
// register, so a source must hold valid/data stable until that edge.
module fifo_wr_arbiter
  import fifo_bfm_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      write_enable,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic [31:0]               pkt_count,
  output arb_state_t                o_dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [NUM_REQ-1:0]  r_hold_vld;
  logic [NUM_REQ-1:0]  r_fresh;
  logic [DATA_W-1:0]   r_hold_data [NUM_REQ];
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic                r_wr_en;
  logic [DATA_W-1:0]   r_wdata;
  logic [31:0]         r_pkt_count;

  logic [NUM_REQ-1:0]  w_capture;
  logic [NUM_REQ-1:0]  w_arb_req;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_any_gnt;
  logic [DATA_W-1:0]   w_gnt_data;
  logic [PTR_W-1:0]    w_gnt_idx;

  assign w_capture = req_valid & ~r_hold_vld;

  // Entries captured at the last edge (r_fresh) sit out one cycle so the
  // capture-to-write latency never drops below two edges.
  assign w_arb_req = (r_state == ST_ARB && !fifo_full) ? (r_hold_vld & ~r_fresh) : '0;
  assign w_any_gnt = |w_gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_req (w_arb_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  // Select the granted packet and its index from the one-hot grant.
  always_comb begin
    w_gnt_data = '0;
    w_gnt_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_data = w_gnt_data | r_hold_data[i];
        w_gnt_idx  = PTR_W'(i);
      end
    end
    w_ptr_nxt = (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + PTR_W'(1);
  end

  // FSM next state: leave ARB only when nothing remains after this grant.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (|r_hold_vld) w_state_nxt = ST_ARB;
      ST_ARB:  if (~|(r_hold_vld & ~w_gnt)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Holding registers: capture on handshake, release on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_vld <= '0;
      r_fresh    <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_hold_data[i] <= '0;
    end else begin
      r_hold_vld <= (r_hold_vld & ~w_gnt) | w_capture;
      r_fresh    <= w_capture;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_capture[i]) r_hold_data[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO write port, round-robin pointer and packet counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_wr_en     <= 1'b0;
      r_wdata     <= '0;
      r_pkt_count <= '0;
    end else begin
      r_wr_en <= w_any_gnt;
      if (w_any_gnt) begin
        r_ptr       <= w_ptr_nxt;
        r_wdata     <= w_gnt_data;
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

  assign req_ready    = ~r_hold_vld;
  assign write_enable = r_wr_en;
  assign fifo_wdata   = r_wdata;
  assign pkt_count    = r_pkt_count;
  assign o_dbg_state  = r_state;

endmodule
